// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   Pipeline stage register with a valid/ready handshake and a 2-entry skid
//   buffer. It carries any stage payload as one packed bus of width W. It adds
//   backpressure and a synchronous flush at full throughput. Its in_ready is
//   taken straight from a flop, so there is no combinational path from
//   out_ready back to in_ready.
//
// Parameters
//   W          payload width in bits (>=1)
//   ZERO_IDLE  1: out_data forced to 0 while out_valid=0; 0: holds last value
//
// Ports
//   clk        in   1  clock, all state on posedge
//   rst_n      in   1  asynchronous active-low reset
//   clr        in   1  synchronous flush, active high, overrides any transfer
//   in_valid   in   1  upstream payload valid
//   in_ready   out  1  stage can accept (registered, equals !skid_valid)
//   in_data    in   W  upstream payload
//   out_valid  out  1  payload available downstream
//   out_ready  in   1  downstream accepts
//   out_data   out  W  payload to downstream (from the main entry)
//   occ        out  2  entries held: 0, 1 or 2
//
// Handshake: a word moves across an interface on a posedge where that
// interface's valid and ready are both 1. The sender holds valid, and the data
// with it, until that happens. While out_valid=1 and out_ready=0 the stage
// keeps out_valid and out_data unchanged.
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int W         = 32*4+2+1+5,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  // State encoding is {main_valid, skid_valid}. The pair (0,1) is never reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;

  logic   acc;
  logic   drn;
  state_e state;  // debug view of the FSM, for checkers to bind to

  assign state     = state_e'({main_valid, skid_valid});
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (clr) begin
      // Flush drops everything, including a word being offered this cycle.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            main_data <= in_data;        // head leaves, new word takes its place
          end else if (acc) begin
            skid_valid <= 1'b1;          // head is stalled, so park the new word behind it
            skid_data  <= in_data;
          end else if (drn) begin
            main_valid <= 1'b0;          // main_data is kept so ZERO_IDLE=0 can show it
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (drn) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          // Recover from the unreachable (0,1) encoding.
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (ZERO_IDLE) begin : g_zero_idle
      assign out_data = main_valid ? main_data : '0;
    end else begin : g_hold_idle
      assign out_data = main_data;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//   Two builds of pipe_stage_buf share one stimulus stream. One is built with
//   ZERO_IDLE=1 and the other with ZERO_IDLE=0. The reference is a plain word
//   queue of depth 2. Each posedge pops the head if downstream takes it, then
//   pushes the offered word if the queue had room before the edge. Flush and
//   reset empty the queue. Directed sections pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         clr       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;

  logic         in_ready,   out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;
  logic         in_ready_h, out_valid_h;
  logic [W-1:0] out_data_h;
  logic [1:0]   occ_h;

  always #5 clk = ~clk;

  pipe_stage_buf #(.W(W), .ZERO_IDLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  pipe_stage_buf #(.W(W), .ZERO_IDLE(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
    .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
    .occ(occ_h)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_q = '0;   // last word that left the queue (hold build shows it)

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics evaluated on inputs stable at the edge.
  always @(posedge clk or negedge rst_n) begin
    bit acc_m, drn_m;
    if (!rst_n || clr) begin
      exp_q.delete();
      last_q = '0;
    end else begin
      acc_m = in_valid && (exp_q.size() < 2);
      drn_m = out_ready && (exp_q.size() > 0);
      if (drn_m) last_q = exp_q.pop_front();
      if (acc_m) exp_q.push_back(in_data);
    end
  end

  // Compare process: every negedge, both builds against the model.
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;

  always @(negedge rst_n) stall_prev = 1'b0;

  always @(negedge clk) begin
    int n;
    logic [W-1:0] head;
    n    = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    check("out_valid",   out_valid,   n > 0);
    check("in_ready",    in_ready,    n < 2);
    check("occ",         occ,         n);
    check("out_data",    out_data,    head);
    check("out_valid_h", out_valid_h, n > 0);
    check("in_ready_h",  in_ready_h,  n < 2);
    check("occ_h",       occ_h,       n);
    check("out_data_h",  out_data_h,  (n > 0) ? head : last_q);
    if (stall_prev && rst_n) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data",  out_data,  stall_data);
    end
    stall_prev = rst_n && out_valid && !out_ready && !clr;
    stall_data = out_data;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    // 1. Reset with a word offered
    drive(1'b1, 16'h12AB, 1'b1);
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_occ",       occ,       2'd0);
    check("rst_out_data",  out_data,  16'h0);
    drive(1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_valid", out_valid, 1'b0);

    // 2. Stream 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1);
      tick();
      check("stream_data", out_data, 64'(i));
      check("stream_occ",  occ,      2'd1);
    end
    drive(1'b0, 16'h0, 1'b1);
    tick();
    check("stream_end_valid", out_valid,  1'b0);
    check("stream_hold_data", out_data_h, 16'd8);

    // 3. A, B, C under backpressure
    drive(1'b1, 16'hA0A0, 1'b0); tick();
    drive(1'b1, 16'hB0B0, 1'b0); tick();
    check("full_occ",      occ,      2'd2);
    check("full_in_ready", in_ready, 1'b0);
    check("full_head",     out_data, 16'hA0A0);
    drive(1'b1, 16'hC0C0, 1'b0); tick();
    check("full_held_occ", occ, 2'd2);
    drive(1'b1, 16'hC0C0, 1'b1); tick();
    check("drain_b",       out_data, 16'hB0B0);
    check("drain_b_ready", in_ready, 1'b1);
    tick();
    check("drain_c",       out_data, 16'hC0C0);
    drive(1'b0, 16'h0, 1'b1); tick();
    check("drain_empty",   out_valid, 1'b0);

    // 4. Flush while FULL with a word offered
    drive(1'b1, 16'hD0D0, 1'b0); tick();
    drive(1'b1, 16'hE0E0, 1'b0); tick();
    check("pre_clr_occ", occ, 2'd2);
    drive(1'b1, 16'hF0F0, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_occ",      occ,       2'd0);
    check("clr_valid",    out_valid, 1'b0);
    check("clr_in_ready", in_ready,  1'b1);
    check("clr_data_h",   out_data_h, 16'h0);
    drive(1'b0, 16'h0, 1'b1); tick();
    check("clr_dropped",  out_valid, 1'b0);

    // 6. Async reset mid-cycle while FULL
    drive(1'b1, 16'h1111, 1'b0); tick();
    drive(1'b1, 16'h2222, 1'b0); tick();
    check("pre_arst_occ", occ, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid",    out_valid,  1'b0);
    check("arst_occ",      occ,        2'd0);
    check("arst_in_ready", in_ready,   1'b1);
    check("arst_data_h",   out_data_h, 16'h0);
    drive(1'b0, 16'h0, 1'b1);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_arst_valid", out_valid, 1'b0);
    drive(1'b1, 16'h5A5A, 1'b1); tick();
    drive(1'b0, 16'h0, 1'b1); tick(); tick();
    check("hold_after_drain",  out_data_h, 16'h5A5A);
    check("zero_after_drain",  out_data,   16'h0);

    // 5. Random traffic against the queue model
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0 ? 1 : 0));
      if (c % 2000 < 1000) out_ready = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) == 0);
      tick();
    end
    clr = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    tick(); tick(); tick();
    check("final_empty", occ, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
